// File: rtl/mips_vic.sv
// mips_vic: vectored interrupt controller for the single-cycle MIPS core.
// Rising edges on irq_in are latched as pending events. Each channel is
// gated by its enable bit, and the lowest-numbered request has priority.
// A one-cycle take_int pulse hands the core a vector address and the
// controller captures the return address. No further interrupt is taken
// until the core issues eret.
// Optional build macro MIPS_VIC_SYNC_EN places a 2-flop synchronizer
// in front of edge detection, which adds two cycles of latency.
module mips_vic #(
    parameter int          NUM_IRQ        = 8,
    parameter logic [31:0] VEC_BASE       = 32'h0000_0100,
    parameter int          VEC_STRIDE_LG2 = 3,
    parameter logic [NUM_IRQ-1:0] IE_RESET = '0,
    localparam int         ID_W           = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ie_we,
    input  logic [NUM_IRQ-1:0] ie_wd,
    output logic [NUM_IRQ-1:0] ie_q,
    output logic [NUM_IRQ-1:0] pending_q,
    input  logic [31:0]        pc_next,
    input  logic               eret,
    output logic               take_int,
    output logic [31:0]        vector_addr,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic [31:0]        epc,
    output logic               in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE_HOT_0 = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    state_t             state;
    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] hist_q;
    logic [NUM_IRQ-1:0] irq_event;
    logic [NUM_IRQ-1:0] req;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;

`ifdef MIPS_VIC_SYNC_EN
    logic [NUM_IRQ-1:0] sync_1;
    logic [NUM_IRQ-1:0] sync_2;

    // Two-stage synchronizer for asynchronous request lines
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= irq_in;
            sync_2 <= sync_1;
        end
    end

    assign irq_src = sync_2;
`else
    assign irq_src = irq_in;
`endif

    // A line that is high while history is low is a new event.
    // History resets to 0, so a line already high at reset release counts once.
    assign irq_event = irq_src & ~hist_q;
    assign req       = pending_q & ie_q;

    // Decoded from registered state only; there is no path from irq_in
    assign take_int    = (state == TAKE);
    assign in_service  = (state == SERVICE);
    assign int_ack     = take_int ? (ONE_HOT_0 << irq_id) : '0;
    assign vector_addr = VEC_BASE + (32'(irq_id) << VEC_STRIDE_LG2);

    // Fixed priority: scanning downward leaves the lowest requesting index
    always_comb begin
        pick_id    = '0;
        pick_valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_id    = ID_W'(i);
                pick_valid = 1'b1;
            end
        end
    end

    // Edge history, enable register, and pending register.
    // A new event has priority over the TAKE clear, so it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q    <= '0;
            ie_q      <= IE_RESET;
            pending_q <= '0;
        end else begin
            hist_q    <= irq_src;
            pending_q <= (pending_q & ~int_ack) | irq_event;
            if (ie_we) begin
                ie_q <= ie_wd;
            end
        end
    end

    // Interrupt sequencing: IDLE picks a channel, TAKE lasts exactly one
    // cycle and captures EPC, and SERVICE waits for eret
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            irq_id <= '0;
            epc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        irq_id <= pick_id;
                        state  <= TAKE;
                    end
                end
                TAKE: begin
                    epc   <= pc_next;
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (eret) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_vic.sv
// tb_mips_vic: self-checking bench for mips_vic (NUM_IRQ=8, default build).
// A per-channel reference model, built from the controller's rules,
// predicts every output once per cycle. Directed scenarios run first,
// then a long randomized run.
module tb_mips_vic;

    localparam int NIRQ = 8;

    logic            clk;
    logic            reset;
    logic [NIRQ-1:0] irq_in;
    logic            ie_we;
    logic [NIRQ-1:0] ie_wd;
    logic [NIRQ-1:0] ie_q;
    logic [NIRQ-1:0] pending_q;
    logic [31:0]     pc_next;
    logic            eret;
    logic            take_int;
    logic [31:0]     vector_addr;
    logic [2:0]      irq_id;
    logic [NIRQ-1:0] int_ack;
    logic [31:0]     epc;
    logic            in_service;

    int compareCount;
    int mismatchCount;

    // Reference model state: 0 = waiting, 1 = taking, 2 = servicing
    int          mPhase;
    int          mId;
    bit          mPend[NIRQ];
    bit          mIe[NIRQ];
    bit          mHist[NIRQ];
    logic [31:0] mEpc;

    mips_vic #(
        .NUM_IRQ(NIRQ),
        .VEC_BASE(32'h0000_0100),
        .VEC_STRIDE_LG2(3),
        .IE_RESET(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq_in(irq_in),
        .ie_we(ie_we),
        .ie_wd(ie_wd),
        .ie_q(ie_q),
        .pending_q(pending_q),
        .pc_next(pc_next),
        .eret(eret),
        .take_int(take_int),
        .vector_addr(vector_addr),
        .irq_id(irq_id),
        .int_ack(int_ack),
        .epc(epc),
        .in_service(in_service)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pack an array of per-channel model bits into a word
    function automatic logic [31:0] packBits(input bit a[NIRQ]);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NIRQ; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mId    = 0;
        mEpc   = '0;
        for (int i = 0; i < NIRQ; i++) begin
            mPend[i] = 1'b0;
            mIe[i]   = 1'b0;
            mHist[i] = 1'b0;
        end
    endtask

    // Advance the model one clock, using the inputs currently applied
    task automatic modelStep();
        int found;
        bit nextPend[NIRQ];
        if (reset) begin
            modelReset();
        end else begin
            found = -1;
            for (int i = 0; i < NIRQ; i++) begin
                if (irq_in[i] && !mHist[i])            nextPend[i] = 1'b1;
                else if (mPhase == 1 && i == mId)      nextPend[i] = 1'b0;
                else                                   nextPend[i] = mPend[i];
            end
            for (int i = NIRQ - 1; i >= 0; i--) begin
                if (mPend[i] && mIe[i]) found = i;
            end
            if (mPhase == 0) begin
                if (found >= 0) begin
                    mId    = found;
                    mPhase = 1;
                end
            end else if (mPhase == 1) begin
                mEpc   = pc_next;
                mPhase = 2;
            end else if (eret) begin
                mPhase = 0;
            end
            for (int i = 0; i < NIRQ; i++) begin
                if (ie_we) mIe[i] = ie_wd[i];
                mHist[i] = irq_in[i];
                mPend[i] = nextPend[i];
            end
        end
    endtask

    task automatic compareAll();
        logic [31:0] expAck;
        expAck = (mPhase == 1) ? (32'd1 << mId) : 32'd0;
        checkOutput("take_int",    {31'd0, take_int},      (mPhase == 1) ? 32'd1 : 32'd0);
        checkOutput("in_service",  {31'd0, in_service},    (mPhase == 2) ? 32'd1 : 32'd0);
        checkOutput("irq_id",      {29'd0, irq_id},        mId);
        checkOutput("vector_addr", vector_addr,            32'h100 + mId * 8);
        checkOutput("int_ack",     {24'd0, int_ack},       expAck);
        checkOutput("epc",         epc,                    mEpc);
        checkOutput("ie_q",        {24'd0, ie_q},          packBits(mIe));
        checkOutput("pending_q",   {24'd0, pending_q},     packBits(mPend));
    endtask

    // One cycle: check at the falling edge, step the model, pass the rising edge
    task automatic tick();
        @(negedge clk);
        compareAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Randomized inputs for one cycle: sparse toggles, rare resets
    task automatic applyStimulus();
        for (int i = 0; i < NIRQ; i++) begin
            if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
        end
        ie_we   = ($urandom_range(0, 15) == 0);
        ie_wd   = 8'($urandom);
        eret    = ($urandom_range(0, 5) == 0);
        pc_next = $urandom & 32'hFFFF_FFFC;
        reset   = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset   = 1'b1;
        irq_in  = '0;
        ie_we   = 1'b0;
        ie_wd   = '0;
        pc_next = '0;
        eret    = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        tick();
        reset = 1'b0;

        // Single interrupt on channel 3 with all channels enabled
        ie_we = 1'b1;
        ie_wd = 8'hFF;
        tick();
        ie_we = 1'b0;
        tick();
        tick();
        irq_in[3] = 1'b1;
        pc_next   = 32'h40;
        tick();
        tick();
        checkOutput("t1_take",   {31'd0, take_int},  32'd1);
        checkOutput("t1_vector", vector_addr,        32'h118);
        checkOutput("t1_ack",    {24'd0, int_ack},   32'h08);
        tick();
        checkOutput("t1_epc",     epc,                 32'h40);
        checkOutput("t1_service", {31'd0, in_service}, 32'd1);
        checkOutput("t1_pending", {24'd0, pending_q},  32'h00);
        irq_in = '0;
        eret   = 1'b1;
        tick();
        eret = 1'b0;
        tick();

        // A new event on channel 4 during its own TAKE must not be lost
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        tick();
        irq_in[4] = 1'b1;
        tick();
        checkOutput("t5_pend4",   {31'd0, pending_q[4]}, 32'd1);
        checkOutput("t5_service", {31'd0, in_service},   32'd1);

        // Reset while in service with several channels pending
        irq_in[0] = 1'b1;
        irq_in[7] = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6_service", {31'd0, in_service}, 32'd0);
        checkOutput("t6_pending", {24'd0, pending_q},  32'h00);
        checkOutput("t6_epc",     epc,                 32'h0);
        checkOutput("t6_ie",      {24'd0, ie_q},       32'h00);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checkOutput("t6_eret", {31'd0, in_service}, 32'd0);

        // Randomized run against the reference model
        for (int c = 0; c < 4000; c++) begin
            applyStimulus();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
